multicycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle MIPS core. It sequences one shared ALU, the unified instruction/data memory port, the IR, PC and register file through fetch, decode, execute, memory and writeback. Each state drives the 3-bit `ALUop` consumed by `ALUcontrol`. Outputs are Moore-decoded from the state register, except `pc_en` during branches.

---
 rtl/multicycle_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: fetch/decode/execute/memory/writeback sequencing.
// Optional memory wait states are enabled by defining MULTICYCLE_MEM_WAIT_EN (adds mem_ready).
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
`ifdef MULTICYCLE_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecR   = 4'd6,
    StRWb     = 4'd7,
    StExecI   = 4'd8,
    StIWb     = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StJumpReg = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] FnJr    = 6'b001000;

  localparam logic [2:0] AluAdd   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluRtype = 3'b010;
  localparam logic [2:0] AluAnd   = 3'b011;
  localparam logic [2:0] AluOr    = 3'b100;
  localparam logic [2:0] AluXor   = 3'b101;
  localparam logic [2:0] AluLui   = 3'b110;
  localparam logic [2:0] AluSlt   = 3'b111;

  state_e state_q, state_d;
  logic   pc_en_raw;
  logic   ready;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_en_raw  = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_op     = 1'b0;
    alu_op     = AluAdd;
    pc_source  = 2'b00;
    illegal    = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (ready) begin
          ir_write  = 1'b1;
          pc_en_raw = 1'b1;
          state_d   = StDecode;
        end
      end
      StDecode: begin
        // Branch target is computed speculatively into ALUOut here.
        alu_src_b = 2'b11;
        ext_op    = 1'b1;
        case (opcode)
          OpRtype:      state_d = (funct == FnJr) ? StJumpReg : StExecR;
          OpLw, OpSw:   state_d = StMemAddr;
          OpBeq, OpBne: state_d = StBranch;
          OpJ:          state_d = StJump;
          OpAddi, OpAddiu, OpAndi, OpOri, OpXori, OpLui, OpSlti: state_d = StExecI;
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 1'b1;
        state_d   = (opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (ready) state_d = StFetch;
      end
      StExecR: begin
        alu_src_a = 1'b1;
        alu_op    = AluRtype;
        state_d   = StRWb;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = StFetch;
      end
      StExecI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 1'b1;
        case (opcode)
          OpAndi: begin alu_op = AluAnd; ext_op = 1'b0; end
          OpOri:  begin alu_op = AluOr;  ext_op = 1'b0; end
          OpXori: begin alu_op = AluXor; ext_op = 1'b0; end
          OpLui:  alu_op = AluLui;
          OpSlti: alu_op = AluSlt;
          default: alu_op = AluAdd;
        endcase
        state_d = StIWb;
      end
      StIWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = AluSub;
        pc_source = 2'b01;
        pc_en_raw = (opcode == OpBne) ? ~zero : zero;
        state_d   = StFetch;
      end
      StJump: begin
        pc_en_raw = 1'b1;
        pc_source = 2'b10;
        state_d   = StFetch;
      end
      StJumpReg: begin
        pc_en_raw = 1'b1;
        pc_source = 2'b11;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Reset forces FETCH outputs, but the PC must not move while reset is held.
  assign pc_en = pc_en_raw & rst_n;
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl; expected per-cycle output vectors are queued
// when an instruction is issued and popped each cycle on the falling clock edge.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
`ifdef MULTICYCLE_MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, ext_op, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;

  typedef struct {
    logic [21:0] v;
    string       tag;
  } sb_t;

  sb_t sb[$];
  int  compared   = 0;
  int  mismatched = 0;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
`ifdef MULTICYCLE_MEM_WAIT_EN
    .mem_ready  (mem_ready),
`endif
    .pc_en      (pc_en),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_op     (ext_op),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Vector layout: pc_en,i_or_d,mem_read,mem_write,ir_write,reg_write,reg_dst,mem_to_reg,
  // alu_src_a,alu_src_b[1:0],ext_op,alu_op[2:0],pc_source[1:0],illegal,state[3:0]
  function automatic logic [21:0] model(input logic [3:0] st, input logic [5:0] op,
                                        input logic z, input logic rn, input logic rdy);
    logic pe, iod, mr, mw, irw, rw, rd, m2r, asa, ext, ill;
    logic [1:0] asb, ps;
    logic [2:0] aop;
    {pe, iod, mr, mw, irw, rw, rd, m2r, asa, ext, ill} = '0;
    asb = 2'b00; ps = 2'b00; aop = 3'b000;
    case (st)
      4'd0: begin mr = 1; asb = 2'b01; irw = rdy; pe = rdy & rn; end
      4'd1: begin
        asb = 2'b11; ext = 1;
        ill = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
                           6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001111,
                           6'b001010});
      end
      4'd2: begin asa = 1; asb = 2'b10; ext = 1; end
      4'd3: begin mr = 1; iod = 1; end
      4'd4: begin rw = 1; m2r = 1; end
      4'd5: begin mw = 1; iod = 1; end
      4'd6: begin asa = 1; aop = 3'b010; end
      4'd7: begin rw = 1; rd = 1; end
      4'd8: begin
        asa = 1; asb = 2'b10; ext = 1;
        case (op)
          6'b001100: begin aop = 3'b011; ext = 0; end
          6'b001101: begin aop = 3'b100; ext = 0; end
          6'b001110: begin aop = 3'b101; ext = 0; end
          6'b001111: aop = 3'b110;
          6'b001010: aop = 3'b111;
          default:   aop = 3'b000;
        endcase
      end
      4'd9:  rw = 1;
      4'd10: begin asa = 1; aop = 3'b001; ps = 2'b01; pe = (op == 6'b000100) ? z : ~z; end
      4'd11: begin pe = 1; ps = 2'b10; end
      4'd12: begin pe = 1; ps = 2'b11; end
      default: ;
    endcase
    return {pe, iod, mr, mw, irw, rw, rd, m2r, asa, asb, ext, aop, ps, ill, st};
  endfunction

  function automatic logic [21:0] observed();
    return {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
            alu_src_a, alu_src_b, ext_op, alu_op, pc_source, illegal, state};
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy, input string tag);
    sb_t e;
    e.v   = model(st, opcode, zero, rst_n, rdy);
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Called just after a falling edge; compares n cycles, leaving time at the next falling edge.
  task automatic drain(input int n);
    sb_t e;
    logic [21:0] act;
    repeat (n) begin
      #1;
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $error("FAIL scoreboard_empty: got %0d entries required 1", sb.size());
      end else begin
        e   = sb.pop_front();
        act = observed();
        assert (act === e.v) else begin
          mismatched++;
          $error("FAIL %s: got %h required %h", e.tag, act, e.v);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input string tag);
    int path[$];
    opcode = op;
    funct  = fn;
    zero   = z;
    path   = '{0, 1};
    case (op)
      6'b100011: path = '{0, 1, 2, 3, 4};
      6'b101011: path = '{0, 1, 2, 5};
      6'b000000: path = (fn == 6'b001000) ? '{0, 1, 12} : '{0, 1, 6, 7};
      6'b000100, 6'b000101: path = '{0, 1, 10};
      6'b000010: path = '{0, 1, 11};
      6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b001111:
        path = '{0, 1, 8, 9};
      default: ;
    endcase
    foreach (path[i]) push(4'(path[i]), 1'b1, tag);
    drain(path.size());
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 6'b000000;
    funct  = 6'b000000;
    zero   = 1'b0;
`ifdef MULTICYCLE_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    @(negedge clk);
    push(4'd0, 1'b1, "reset_state");
    drain(1);
    rst_n = 1'b1;

    issue(6'b100011, 6'b000000, 1'b0, "lw");
    issue(6'b101011, 6'b000000, 1'b0, "sw");
    issue(6'b000000, 6'b001000, 1'b0, "jr");
    issue(6'b000000, 6'b100000, 1'b0, "add");
    issue(6'b001101, 6'b000000, 1'b0, "ori");
    issue(6'b000100, 6'b000000, 1'b1, "beq_taken");
    issue(6'b000101, 6'b000000, 1'b1, "bne_not_taken");
    issue(6'b000101, 6'b000000, 1'b0, "bne_taken");
    issue(6'b000100, 6'b000000, 1'b0, "beq_not_taken");
    issue(6'b000010, 6'b000000, 1'b0, "j");
    issue(6'b111111, 6'b000000, 1'b0, "illegal");
    issue(6'b001111, 6'b000000, 1'b0, "lui");
    issue(6'b001100, 6'b000000, 1'b0, "andi");
    issue(6'b001110, 6'b000000, 1'b0, "xori");
    issue(6'b001010, 6'b000000, 1'b0, "slti");
    issue(6'b001001, 6'b000000, 1'b0, "addiu");
    issue(6'b000011, 6'b000000, 1'b0, "jal_illegal");

    // Reset asserted mid-lw (in MEM_RD) and held for 3 cycles.
    opcode = 6'b100011;
    push(4'd0, 1'b1, "lw_pre_reset");
    push(4'd1, 1'b1, "lw_pre_reset");
    push(4'd2, 1'b1, "lw_pre_reset");
    drain(3);
    rst_n = 1'b0;
    repeat (3) push(4'd0, 1'b1, "reset_hold");
    drain(3);
    rst_n = 1'b1;
    issue(6'b100011, 6'b000000, 1'b0, "lw_after_reset");

`ifdef MULTICYCLE_MEM_WAIT_EN
    // Two wait cycles in MEM_RD stretch lw to 7 cycles.
    opcode = 6'b100011;
    push(4'd0, 1'b1, "lw_wait");
    push(4'd1, 1'b1, "lw_wait");
    push(4'd2, 1'b1, "lw_wait");
    drain(3);
    mem_ready = 1'b0;
    push(4'd3, 1'b0, "lw_wait_rd");
    push(4'd3, 1'b0, "lw_wait_rd");
    drain(2);
    mem_ready = 1'b1;
    push(4'd3, 1'b1, "lw_wait_rd");
    push(4'd4, 1'b1, "lw_wait");
    drain(2);
    // Fetch stall: no IR load or PC update until memory is ready.
    mem_ready = 1'b0;
    opcode    = 6'b000010;
    push(4'd0, 1'b0, "fetch_wait");
    push(4'd0, 1'b0, "fetch_wait");
    drain(2);
    mem_ready = 1'b1;
    push(4'd0, 1'b1, "fetch_wait");
    push(4'd1, 1'b1, "fetch_wait");
    push(4'd11, 1'b1, "fetch_wait");
    drain(3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
